// File: rtl/tag_reset_pkg.sv
// Shared types for the PLL reset sequencer: state encoding and a width helper.
// Latency: n/a (types only).
// Backpressure: n/a.
package tag_reset_pkg;

  localparam int SEQ_STATE_W = 3;

  typedef enum logic [SEQ_STATE_W-1:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } seq_state_t;

  // Smallest r with 2**r >= value; used to sanity-check counter widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/tag_sync_2ff.sv
// Two-flop synchronizer for slow level signals crossing into clk.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; samples every cycle.
module tag_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sdram_pll_reset_sequencer.sv
// Sequences PLL reset, debounces lock, then releases system reset; retries/fails on timeouts.
// Latency: outputs registered from next state; pll_locked seen 2 cycles late via synchronizer.
// Backpressure: none; soft_restart is a one-cycle pulse honoured in any state.
module sdram_pll_reset_sequencer
  import tag_reset_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 17
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pll_locked,
  input  logic                   soft_restart,
  output logic                   pll_rst,
  output logic                   sys_reset_n,
  output logic                   lock_fail,
  output logic [7:0]             lock_loss_count,
  output logic [SEQ_STATE_W-1:0] seq_state
);

  localparam int MAX_CYC_A = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CYC   = (MAX_CYC_A > LOCK_TIMEOUT_CYCLES) ? MAX_CYC_A : LOCK_TIMEOUT_CYCLES;

  if (CNT_W < clog2(MAX_CYC) + 1) begin : g_cnt_w_check
    $error("CNT_W too small for the largest cycle parameter");
  end

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  logic             locked_s;
  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       retry, retry_nxt, retry_inc;
  logic [7:0]       loss_nxt;

  tag_sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (locked_s)
  );

  assign retry_inc = retry + 4'd1;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry;
    loss_nxt  = lock_loss_count;
    // soft_restart outranks everything, including a lock loss seen in RUN.
    if (soft_restart) begin
      state_nxt = PLL_RESET;
      cnt_nxt   = '0;
      retry_nxt = '0;
    end else begin
      case (state)
        PLL_RESET: begin
          if (cnt == PLL_RST_LAST) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_nxt = STABLE;
            cnt_nxt   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            retry_nxt = retry_inc;
            cnt_nxt   = '0;
            state_nxt = (retry_inc == RETRY_LIMIT) ? FAIL : PLL_RESET;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
          end else if (cnt == STABLE_LAST) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
            retry_nxt = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_nxt = PLL_RESET;
            cnt_nxt   = '0;
            if (lock_loss_count != 8'hFF) loss_nxt = lock_loss_count + 8'd1;
          end
        end
        FAIL: begin
          state_nxt = FAIL;
        end
        default: begin
          state_nxt = PLL_RESET;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= PLL_RESET;
      cnt             <= '0;
      retry           <= '0;
      lock_loss_count <= '0;
      pll_rst         <= 1'b1;
      sys_reset_n     <= 1'b0;
      lock_fail       <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      retry           <= retry_nxt;
      lock_loss_count <= loss_nxt;
      pll_rst         <= (state_nxt == PLL_RESET);
      sys_reset_n     <= (state_nxt == RUN);
      lock_fail       <= (state_nxt == FAIL);
    end
  end

  assign seq_state = state;

endmodule

// File: doc/sdram_pll_reset_sequencer.md
Name: sdram_pll_reset_sequencer

Overview:
Sits directly downstream of the SDRAM/system PLL wrapper and consumes its `locked` output. It also drives that wrapper's active-high `rst` input. The block sequences PLL reset, waits for a debounced stable lock, and then releases a system reset to the SDRAM controller and Nios domain. On lock loss it reasserts system reset and re-runs the PLL; after repeated lock timeouts it parks in a fail state.

Parameters:
- PLL_RST_CYCLES, 16: cycles `pll_rst` is held high per attempt (min 2).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before release (min 2).
- LOCK_TIMEOUT_CYCLES, 65536: cycles to wait for lock before a retry (min 2).
- MAX_RETRIES, 3: lock timeouts tolerated before FAIL (1..15).
- CNT_W, 17: counter width, must be ≥ clog2 of the largest cycle parameter +1.

Ports:
- clk  in  1  free-running 50 MHz reference clock, same net as the PLL refclk.
- reset_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL locked, asynchronous to clk.
- soft_restart  in  1  synchronous one-cycle pulse; restarts the sequence from any state.
- pll_rst  out  1  active-high reset to the PLL.
- sys_reset_n  out  1  active-low system reset; consumers re-synchronize deassertion into outclk domains.
- lock_fail  out  1  high in the FAIL state.
- lock_loss_count  out  8  number of lock losses while in RUN; saturates at 255.
- seq_state  out  3  current state encoding, for debug/PIO.

Behaviour:
- Clock and reset: one clock `clk`; reset `reset_n` is asynchronous and active-low. All flops reset asynchronously.
- Reset values: state = PLL_RESET, pll_rst = 1, sys_reset_n = 0, lock_fail = 0, lock_loss_count = 0, cycle counter = 0, retry counter = 0, synchronizer flops = 0.
- `pll_locked` passes through a 2-flop synchronizer, giving `locked_s` (2 cycles latency). All decisions use `locked_s` only.
- All outputs are registered and decoded from the next state, so each output changes on the same edge as the state.
- State encoding: PLL_RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- PLL_RESET:
  - pll_rst = 1, sys_reset_n = 0.
  - Counter increments each cycle. When counter == PLL_RST_CYCLES-1, go to WAIT_LOCK and clear the counter.
- WAIT_LOCK:
  - pll_rst = 0, sys_reset_n = 0.
  - If `locked_s`, go to STABLE and clear the counter.
  - Else the counter increments. When counter == LOCK_TIMEOUT_CYCLES-1, increment the retry counter. Go to FAIL if the new retry value == MAX_RETRIES, else go to PLL_RESET. Clear the counter in both cases.
- STABLE:
  - sys_reset_n = 0.
  - If `!locked_s`, return to WAIT_LOCK, clear the counter, and leave the retry counter unchanged. A glitch restarts the debounce.
  - Else, when counter == LOCK_STABLE_CYCLES-1, go to RUN and clear the retry counter.
- RUN:
  - sys_reset_n = 1.
  - If `!locked_s`, sys_reset_n goes to 0 on that edge, lock_loss_count increments (saturating), and the state goes to PLL_RESET.
- FAIL:
  - pll_rst = 0, sys_reset_n = 0, lock_fail = 1.
  - Exit only via reset_n or soft_restart.
- soft_restart:
  - From any state, go to PLL_RESET and clear the counter, the retry counter and lock_fail.
  - lock_loss_count is not cleared.
  - soft_restart has priority over every other transition, including simultaneous lock loss in RUN; that case does not increment lock_loss_count.
- Wrap-around: the counter never exceeds its terminal compare. lock_loss_count holds at 255.
- `pll_locked` toggling during PLL_RESET is ignored.
- reset_n asserted mid-sequence forces the reset values immediately, asynchronously.

Decomposition:
- Shared package `tag_reset_pkg`:
  - state enum `seq_state_t`, with the encodings above;
  - `SEQ_STATE_W = 3`;
  - a `clog2` helper for CNT_W checks.
- Sub-module `tag_sync_2ff`: a parameterized-width 2-flop synchronizer with async active-low reset, reused for `locked`. The FSM and counters stay in the top module.

Test Plan:
Bench parameters: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
- Clean bring-up:
  - Stimulus: pll_locked=1 constantly; reset_n released before edge 0.
  - Response: pll_rst high for edges 0–3 and low from edge 4. STABLE entered at edge 5. sys_reset_n rises at edge 13, with seq_state=3.
- Debounce glitch:
  - Stimulus: pll_locked drops for 1 cycle at STABLE count 5.
  - Response: state returns to WAIT_LOCK and sys_reset_n stays 0. Release occurs a full 8 stable cycles after relock; retry count is unchanged.
- Timeout to FAIL:
  - Stimulus: pll_locked=0 forever.
  - Response: two 4-cycle pll_rst pulses separated by 32-cycle waits. lock_fail=1 and seq_state=4, with pll_rst=0 and sys_reset_n=0 held thereafter.
- Lock loss in RUN:
  - Stimulus: drop pll_locked in RUN.
  - Response: sys_reset_n falls exactly 2 cycles after the drop (synchronizer) plus 1 edge. lock_loss_count goes 0→1 and pll_rst goes high on the same edge. After forcing 300 losses, the count reads 255.
- soft_restart:
  - From FAIL: lock_fail clears and pll_rst goes high on the next edge.
  - Coincident with lock loss in RUN: state=PLL_RESET and lock_loss_count is unchanged.
- Async reset mid-STABLE:
  - Stimulus: reset_n low between edges.
  - Response: outputs take their reset values immediately, without waiting for an edge. The sequence restarts from PLL_RESET.
